controle_jogo_param: RTL and testbench

- Parametrised game controller FSM for the memory game; next generation of the existing control unit.
- Absorbs the address, limit, LED-interval and response-timeout counters that the datapath currently owns.
- Adds configurable sequence depth, timing, a lives counter and a cumulative/fixed sequence mode.
- Drives the external sequence memory and the jogada register and comparator.

---
 rtl/controle_jogo_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_controle_jogo_param.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo_param.sv
// controle_jogo_param
// Game controller for the memory game. It owns the sequence address,
// the round limit, the LED on/dark interval timer, the response timeout,
// the lives counter and the cumulative/fixed sequence mode. It drives the
// external sequence memory together with the jogada register and comparator.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   iniciar             one-cycle start pulse (honoured in INICIAL and final states)
//   jogada              one-cycle pulse, a button was pressed
//   igual               comparator result, looked at in COMPARACAO
//   modo_timeout        response timeout enable, captured in PREPARACAO
//   modo_cumulativo     player appends each new element, captured in PREPARACAO
//   endereco, limite    sequence memory address / index of last element of round
//   registra_jogada     memory write strobe (only in ADICIONA_JOGADA, with jogada)
//   registrarR          load strobe for the jogada register
//   conf_leds           show the memory colour on the LEDs
//   acertou/errou/pronto  end-of-game flags
//   vidas               lives remaining
//   db_estado           current state code, for debug displays
module controle_jogo_param #(
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4,
   parameter int T_LED      = 1000,
   parameter int T_APAGADO  = 500,
   parameter int T_RESPOSTA = 5000,
   parameter int TIMER_W    = 16,
   parameter int VIDAS      = 3,
   parameter int VIDAS_W    = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               jogada,
   input  logic               igual,
   input  logic               modo_timeout,
   input  logic               modo_cumulativo,
   output logic [ADDR_W-1:0]  endereco,
   output logic [ADDR_W-1:0]  limite,
   output logic               registra_jogada,
   output logic               registrarR,
   output logic               conf_leds,
   output logic               acertou,
   output logic               errou,
   output logic               pronto,
   output logic [VIDAS_W-1:0] vidas,
   output logic [4:0]         db_estado
);

   typedef enum logic [4:0] {
      INICIAL         = 5'd0,
      PREPARACAO      = 5'd1,
      CARREGA_LED     = 5'd2,
      MOSTRA_LED      = 5'd3,
      MOSTRA_APAGADO  = 5'd4,
      ESPERA          = 5'd5,
      REGISTRA        = 5'd6,
      COMPARACAO      = 5'd7,
      PROXIMO         = 5'd8,
      PERDE_VIDA      = 5'd9,
      ADICIONA_JOGADA = 5'd10,
      PROXIMA_RODADA  = 5'd11,
      FINAL_ACERTO    = 5'd12,
      FINAL_ERRO      = 5'd13,
      FINAL_TIMEOUT   = 5'd14
   } estado_t;

   localparam logic [ADDR_W-1:0]  ULTIMO       = ADDR_W'(DEPTH - 1);
   localparam logic [TIMER_W-1:0] FIM_LED      = TIMER_W'(T_LED - 1);
   localparam logic [TIMER_W-1:0] FIM_APAGADO  = TIMER_W'(T_APAGADO - 1);
   localparam logic [TIMER_W-1:0] FIM_RESPOSTA = TIMER_W'(T_RESPOSTA - 1);
   localparam logic [VIDAS_W-1:0] VIDAS_INI    = VIDAS_W'(VIDAS);

   estado_t            state_q, state_d;
   logic [ADDR_W-1:0]  endereco_q, endereco_d;
   logic [ADDR_W-1:0]  limite_q, limite_d;
   logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
   logic [VIDAS_W-1:0] vidas_q, vidas_d;
   logic               modo_timeout_q, modo_timeout_d;
   logic               modo_cumulativo_q, modo_cumulativo_d;
   logic               resposta_expirou;

   // The timer sticks at all-ones instead of wrapping, so a very long wait
   // can never alias back into a short one.
   assign timer_inc = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + TIMER_W'(1);

   // A missed answer only counts when the timeout mode was captured at game start.
   assign resposta_expirou = modo_timeout_q && (timer_q == FIM_RESPOSTA);

   // State and datapath registers. Reset puts the controller back in INICIAL
   // with a full set of lives and both mode registers cleared.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q           <= INICIAL;
         endereco_q        <= '0;
         limite_q          <= '0;
         timer_q           <= '0;
         vidas_q           <= VIDAS_INI;
         modo_timeout_q    <= 1'b0;
         modo_cumulativo_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         endereco_q        <= endereco_d;
         limite_q          <= limite_d;
         timer_q           <= timer_d;
         vidas_q           <= vidas_d;
         modo_timeout_q    <= modo_timeout_d;
         modo_cumulativo_q <= modo_cumulativo_d;
      end
   end

   // Next-state and counter updates. The timer only advances in the four
   // timed states and is cleared everywhere else, which gives every timed
   // state a fresh count on entry.
   always_comb begin
      state_d           = state_q;
      endereco_d        = endereco_q;
      limite_d          = limite_q;
      timer_d           = '0;
      vidas_d           = vidas_q;
      modo_timeout_d    = modo_timeout_q;
      modo_cumulativo_d = modo_cumulativo_q;
      case (state_q)
         INICIAL: begin
            if (iniciar) state_d = PREPARACAO;
         end
         PREPARACAO: begin
            modo_timeout_d    = modo_timeout;
            modo_cumulativo_d = modo_cumulativo;
            endereco_d        = '0;
            limite_d          = '0;
            vidas_d           = VIDAS_INI;
            state_d           = CARREGA_LED;
         end
         CARREGA_LED: begin
            state_d = MOSTRA_LED;
         end
         MOSTRA_LED: begin
            if (timer_q == FIM_LED) state_d = MOSTRA_APAGADO;
            else timer_d = timer_inc;
         end
         MOSTRA_APAGADO: begin
            if (timer_q == FIM_APAGADO) begin
               if (endereco_q == limite_q) begin
                  endereco_d = '0;
                  state_d    = ESPERA;
               end else begin
                  endereco_d = endereco_q + ADDR_W'(1);
                  state_d    = CARREGA_LED;
               end
            end else begin
               timer_d = timer_inc;
            end
         end
         ESPERA: begin
            timer_d = timer_inc;
            // A press in the very last cycle still counts as an answer.
            if (jogada) state_d = REGISTRA;
            else if (resposta_expirou) state_d = FINAL_TIMEOUT;
         end
         REGISTRA: begin
            state_d = COMPARACAO;
         end
         COMPARACAO: begin
            if (!igual) state_d = PERDE_VIDA;
            else if (endereco_q != limite_q) state_d = PROXIMO;
            else if (limite_q == ULTIMO) state_d = FINAL_ACERTO;
            else if (modo_cumulativo_q) begin
               // The player's next press is stored one slot past the round.
               endereco_d = endereco_q + ADDR_W'(1);
               state_d    = ADICIONA_JOGADA;
            end else begin
               state_d = PROXIMA_RODADA;
            end
         end
         PROXIMO: begin
            endereco_d = endereco_q + ADDR_W'(1);
            state_d    = ESPERA;
         end
         PERDE_VIDA: begin
            // The last life is kept on display when the game is lost.
            if (vidas_q == VIDAS_W'(1)) begin
               state_d = FINAL_ERRO;
            end else begin
               vidas_d    = vidas_q - VIDAS_W'(1);
               endereco_d = '0;
               state_d    = CARREGA_LED;
            end
         end
         ADICIONA_JOGADA: begin
            timer_d = timer_inc;
            if (jogada) state_d = PROXIMA_RODADA;
            else if (resposta_expirou) state_d = FINAL_TIMEOUT;
         end
         PROXIMA_RODADA: begin
            if (limite_q != ULTIMO) limite_d = limite_q + ADDR_W'(1);
            endereco_d = '0;
            state_d    = CARREGA_LED;
         end
         FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT: begin
            if (iniciar) state_d = PREPARACAO;
         end
         default: begin
            state_d = INICIAL;
         end
      endcase
   end

   // Output decode. Everything is Moore except the memory write strobe,
   // which follows jogada directly so exactly one write lands in the press
   // cycle; it is also masked by reset so no write slips out after reset.
   always_comb begin
      conf_leds       = 1'b0;
      registrarR      = 1'b0;
      registra_jogada = 1'b0;
      acertou         = 1'b0;
      errou           = 1'b0;
      pronto          = 1'b0;
      case (state_q)
         MOSTRA_LED:      conf_leds = 1'b1;
         REGISTRA:        registrarR = 1'b1;
         ADICIONA_JOGADA: registra_jogada = jogada & ~reset;
         FINAL_ACERTO: begin
            acertou = 1'b1;
            pronto  = 1'b1;
         end
         FINAL_ERRO, FINAL_TIMEOUT: begin
            errou  = 1'b1;
            pronto = 1'b1;
         end
         default: ;
      endcase
   end

   assign endereco  = endereco_q;
   assign limite    = limite_q;
   assign vidas     = vidas_q;
   assign db_estado = state_q;

endmodule

// File: tb/tb_controle_jogo_param.sv
// tb_controle_jogo_param
// Self-checking bench for controle_jogo_param with a small configuration
// (4 rounds, 3-cycle LED, 2-cycle gap, 10-cycle timeout, 3 lives). The bench
// plays games as a player would and predicts every observable value from the
// rules of the game: how many colours a round shows, how long it takes, which
// address each answer is taken at, how lives and rounds evolve, how it ends.
module tb_controle_jogo_param;

   localparam int DEPTH_P      = 4;
   localparam int ADDR_W_P     = 2;
   localparam int T_LED_P      = 3;
   localparam int T_APAGADO_P  = 2;
   localparam int T_RESPOSTA_P = 10;
   localparam int TIMER_W_P    = 4;
   localparam int VIDAS_P      = 3;
   localparam int VIDAS_W_P    = 2;

   localparam logic [4:0] S_INICIAL    = 5'd0;
   localparam logic [4:0] S_PREPARACAO = 5'd1;
   localparam logic [4:0] S_CARREGA    = 5'd2;
   localparam logic [4:0] S_LED        = 5'd3;
   localparam logic [4:0] S_APAGADO    = 5'd4;
   localparam logic [4:0] S_ESPERA     = 5'd5;
   localparam logic [4:0] S_REGISTRA   = 5'd6;
   localparam logic [4:0] S_COMPARACAO = 5'd7;
   localparam logic [4:0] S_PROXIMO    = 5'd8;
   localparam logic [4:0] S_PERDE_VIDA = 5'd9;
   localparam logic [4:0] S_ADICIONA   = 5'd10;
   localparam logic [4:0] S_PROX_RODADA = 5'd11;
   localparam logic [4:0] S_ACERTO     = 5'd12;
   localparam logic [4:0] S_ERRO       = 5'd13;
   localparam logic [4:0] S_TIMEOUT    = 5'd14;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 iniciar, jogada, igual, modo_timeout, modo_cumulativo;
   logic [ADDR_W_P-1:0]  endereco, limite;
   logic                 registra_jogada, registrarR, conf_leds;
   logic                 acertou, errou, pronto;
   logic [VIDAS_W_P-1:0] vidas;
   logic [4:0]           db_estado;

   int total = 0;
   int bad   = 0;
   int dec_q[$];

   typedef struct {
      logic       ini;
      logic       jog;
      logic       ig;
      logic [4:0] est;
      logic       conf;
      logic       reg_r;
      logic [1:0] ende;
      logic [1:0] lim;
   } vec_t;
   vec_t vecs[$];

   controle_jogo_param #(
      .DEPTH(DEPTH_P), .ADDR_W(ADDR_W_P), .T_LED(T_LED_P), .T_APAGADO(T_APAGADO_P),
      .T_RESPOSTA(T_RESPOSTA_P), .TIMER_W(TIMER_W_P), .VIDAS(VIDAS_P), .VIDAS_W(VIDAS_W_P)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
      .modo_timeout(modo_timeout), .modo_cumulativo(modo_cumulativo),
      .endereco(endereco), .limite(limite), .registra_jogada(registra_jogada),
      .registrarR(registrarR), .conf_leds(conf_leds), .acertou(acertou), .errou(errou),
      .pronto(pronto), .vidas(vidas), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Outputs are looked at 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic ini, input logic jog, input logic ig);
      iniciar = ini;
      jogada  = jog;
      igual   = ig;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic ini, input logic jog, input logic ig, input logic [4:0] est,
                         input logic conf, input logic reg_r, input logic [1:0] ende, input logic [1:0] lim);
      vec_t v;
      v.ini = ini; v.jog = jog; v.ig = ig; v.est = est;
      v.conf = conf; v.reg_r = reg_r; v.ende = ende; v.lim = lim;
      vecs.push_back(v);
   endtask

   task automatic waitState(input logic [4:0] target, input int budget, output int n, output int leds);
      n = 0;
      leds = 0;
      while (db_estado !== target && n < budget) begin
         tick();
         n++;
         if (conf_leds === 1'b1) leds++;
      end
      checkOutput($sformatf("reach_state_%0d", target), db_estado, target);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // 0 = correct answer, 1 = wrong answer, 2 = stay idle until timeout
   task automatic nextDecision(input bit rnd, input bit to, output int d);
      int r;
      if (dec_q.size() > 0) d = dec_q.pop_front();
      else if (rnd) begin
         r = $urandom_range(0, 19);
         if (r < 3) d = 1;
         else if (r == 3 && to) d = 2;
         else d = 0;
      end else d = 0;
   endtask

   task automatic expectTimeout(input logic [4:0] st);
      int n;
      n = 0;
      while (db_estado === st && n < T_RESPOSTA_P + 5) begin
         tick();
         n++;
      end
      checkOutput("timeout_cycles", n, T_RESPOSTA_P);
      checkOutput("timeout_state", db_estado, S_TIMEOUT);
      checkOutput("timeout_errou", errou, 1);
      checkOutput("timeout_pronto", pronto, 1);
      checkOutput("timeout_acertou", acertou, 0);
   endtask

   // Plays one full game from INICIAL or a final state, following the rules
   // of the game to predict every round.
   task automatic playGame(input bit cum, input bit to, input bit rnd);
      int  round_n, lives, n, leds, dec, d, extra;
      bit  done, sair;
      round_n = 0;
      lives   = VIDAS_P;
      done    = 0;
      modo_cumulativo = cum;
      modo_timeout    = to;
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput("game_prep", db_estado, S_PREPARACAO);
      tick();
      extra = 1;
      if (rnd) begin
         modo_cumulativo = ~cum;
         modo_timeout    = ~to;
      end
      while (!done) begin
         waitState(S_ESPERA, (round_n + 1) * (1 + T_LED_P + T_APAGADO_P) + 6, n, leds);
         if (db_estado !== S_ESPERA) begin
            done = 1;
         end else begin
            checkOutput("show_leds", leds, (round_n + 1) * T_LED_P);
            checkOutput("show_cycles", n + extra, (round_n + 1) * (1 + T_LED_P + T_APAGADO_P) + 1);
            extra = 0;
            checkOutput("espera_limite", limite, round_n);
            checkOutput("espera_vidas", vidas, lives);
            sair = 0;
            for (int p = 0; p <= round_n && !done && !sair; p++) begin
               checkOutput("espera_endereco", endereco, p);
               nextDecision(rnd, to, dec);
               if (dec == 2 && to) begin
                  expectTimeout(S_ESPERA);
                  done = 1;
               end else begin
                  d = rnd ? int'($urandom_range(0, 3)) : 0;
                  for (int k = 0; k < d; k++) tick();
                  applyStimulus(0, 1, dec != 1);
                  #1;
                  checkOutput("no_write_espera", registra_jogada, 0);
                  tick();
                  applyStimulus(0, 0, dec != 1);
                  checkOutput("registra_state", db_estado, S_REGISTRA);
                  checkOutput("registrarR", registrarR, 1);
                  tick();
                  checkOutput("comparacao_state", db_estado, S_COMPARACAO);
                  tick();
                  if (dec == 1) begin
                     checkOutput("perde_vida_state", db_estado, S_PERDE_VIDA);
                     lives--;
                     if (lives == 0) begin
                        tick();
                        checkOutput("erro_state", db_estado, S_ERRO);
                        checkOutput("erro_vidas", vidas, 1);
                        checkOutput("erro_errou", errou, 1);
                        checkOutput("erro_pronto", pronto, 1);
                        checkOutput("erro_acertou", acertou, 0);
                        done = 1;
                     end else begin
                        sair = 1;
                     end
                  end else if (p < round_n) begin
                     checkOutput("proximo_state", db_estado, S_PROXIMO);
                     tick();
                     checkOutput("volta_espera", db_estado, S_ESPERA);
                  end else if (round_n == DEPTH_P - 1) begin
                     checkOutput("acerto_state", db_estado, S_ACERTO);
                     checkOutput("acerto_acertou", acertou, 1);
                     checkOutput("acerto_pronto", pronto, 1);
                     checkOutput("acerto_errou", errou, 0);
                     done = 1;
                  end else if (cum) begin
                     checkOutput("adiciona_state", db_estado, S_ADICIONA);
                     checkOutput("adiciona_endereco", endereco, round_n + 1);
                     nextDecision(rnd, to, dec);
                     if (dec == 2 && to) begin
                        expectTimeout(S_ADICIONA);
                        done = 1;
                     end else begin
                        d = rnd ? int'($urandom_range(0, 3)) : 0;
                        for (int k = 0; k < d; k++) begin
                           checkOutput("write_idle", registra_jogada, 0);
                           tick();
                        end
                        applyStimulus(0, 1, 1);
                        #1;
                        checkOutput("write_pulse", registra_jogada, 1);
                        tick();
                        applyStimulus(0, 0, 1);
                        checkOutput("write_after", registra_jogada, 0);
                        checkOutput("cum_prox_rodada", db_estado, S_PROX_RODADA);
                        round_n++;
                        sair = 1;
                     end
                  end else begin
                     checkOutput("fix_prox_rodada", db_estado, S_PROX_RODADA);
                     round_n++;
                     sair = 1;
                  end
               end
            end
         end
      end
   endtask

   initial begin
      int n, leds;
      reset = 1'b1;
      modo_timeout = 1'b0;
      modo_cumulativo = 1'b0;
      applyStimulus(0, 0, 0);
      tick();
      tick();

      // Reset values while reset is held.
      checkOutput("rst_estado", db_estado, S_INICIAL);
      checkOutput("rst_vidas", vidas, VIDAS_P);
      checkOutput("rst_endereco", endereco, 0);
      checkOutput("rst_limite", limite, 0);
      checkOutput("rst_conf_leds", conf_leds, 0);
      checkOutput("rst_pronto", pronto, 0);
      checkOutput("rst_registrarR", registrarR, 0);
      checkOutput("rst_registra", registra_jogada, 0);
      reset = 1'b0;
      tick();

      // Fixed mode, round 0 answered correctly, then the 2-colour show of
      // round 1. The iniciar pulse in the middle of a show must be ignored.
      addVec(1, 0, 0, S_PREPARACAO, 0, 0, 0, 0);
      addVec(0, 0, 0, S_CARREGA,    0, 0, 0, 0);
      addVec(0, 0, 0, S_LED,        1, 0, 0, 0);
      addVec(0, 0, 0, S_LED,        1, 0, 0, 0);
      addVec(0, 0, 0, S_LED,        1, 0, 0, 0);
      addVec(0, 0, 0, S_APAGADO,    0, 0, 0, 0);
      addVec(0, 0, 0, S_APAGADO,    0, 0, 0, 0);
      addVec(0, 0, 0, S_ESPERA,     0, 0, 0, 0);
      addVec(0, 1, 1, S_REGISTRA,   0, 1, 0, 0);
      addVec(0, 0, 1, S_COMPARACAO, 0, 0, 0, 0);
      addVec(0, 0, 1, S_PROX_RODADA, 0, 0, 0, 0);
      addVec(0, 0, 0, S_CARREGA,    0, 0, 0, 1);
      addVec(0, 0, 0, S_LED,        1, 0, 0, 1);
      addVec(1, 0, 0, S_LED,        1, 0, 0, 1);
      addVec(0, 0, 0, S_LED,        1, 0, 0, 1);
      addVec(0, 0, 0, S_APAGADO,    0, 0, 0, 1);
      addVec(0, 0, 0, S_APAGADO,    0, 0, 0, 1);
      addVec(0, 0, 0, S_CARREGA,    0, 0, 1, 1);
      addVec(0, 0, 0, S_LED,        1, 0, 1, 1);
      addVec(0, 0, 0, S_LED,        1, 0, 1, 1);
      addVec(0, 0, 0, S_LED,        1, 0, 1, 1);
      addVec(0, 0, 0, S_APAGADO,    0, 0, 1, 1);
      addVec(0, 0, 0, S_APAGADO,    0, 0, 1, 1);
      addVec(0, 0, 0, S_ESPERA,     0, 0, 0, 1);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].ini, vecs[i].jog, vecs[i].ig);
         tick();
         checkOutput($sformatf("vec%0d_estado", i), db_estado, vecs[i].est);
         checkOutput($sformatf("vec%0d_conf_leds", i), conf_leds, vecs[i].conf);
         checkOutput($sformatf("vec%0d_registrarR", i), registrarR, vecs[i].reg_r);
         checkOutput($sformatf("vec%0d_endereco", i), endereco, vecs[i].ende);
         checkOutput($sformatf("vec%0d_limite", i), limite, vecs[i].lim);
      end

      // Miss round 1, then reset in the middle of the replay's second colour.
      applyStimulus(0, 1, 0);
      tick();
      applyStimulus(0, 0, 0);
      tick();
      tick();
      checkOutput("miss_perde_vida", db_estado, S_PERDE_VIDA);
      n = 0;
      while (!(db_estado === S_LED && endereco === 2'd1) && n < 40) begin
         tick();
         n++;
      end
      checkOutput("replay_led_end1", db_estado === S_LED && endereco === 2'd1, 1);
      checkOutput("replay_vidas", vidas, 2);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_led_estado", db_estado, S_INICIAL);
      checkOutput("rst_led_endereco", endereco, 0);
      checkOutput("rst_led_limite", limite, 0);
      checkOutput("rst_led_vidas", vidas, VIDAS_P);
      checkOutput("rst_led_conf", conf_leds, 0);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("rst_led_stays", db_estado, S_INICIAL);

      // Fixed mode, all answers correct: win after round 3.
      playGame(0, 0, 0);

      // One correct round, then three misses on round 1.
      dec_q = '{0, 1, 1, 1};
      playGame(0, 0, 0);

      // Timeout with no press, then a press in the 10th waiting cycle.
      dec_q = '{2};
      playGame(0, 1, 0);
      modo_timeout = 1'b1;
      modo_cumulativo = 1'b0;
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      waitState(S_ESPERA, 20, n, leds);
      for (int k = 0; k < T_RESPOSTA_P - 1; k++) tick();
      checkOutput("espera_cycle10", db_estado, S_ESPERA);
      applyStimulus(0, 1, 1);
      tick();
      applyStimulus(0, 0, 1);
      checkOutput("late_press_registra", db_estado, S_REGISTRA);
      doReset();

      // Cumulative mode, all answers correct.
      playGame(1, 0, 0);

      // Reset while a write is being requested in ADICIONA_JOGADA.
      modo_cumulativo = 1'b1;
      modo_timeout = 1'b0;
      applyStimulus(1, 0, 0);
      tick();
      applyStimulus(0, 0, 0);
      waitState(S_ESPERA, 20, n, leds);
      applyStimulus(0, 1, 1);
      tick();
      applyStimulus(0, 0, 1);
      waitState(S_ADICIONA, 5, n, leds);
      checkOutput("add_endereco", endereco, 1);
      #2;
      jogada = 1'b1;
      reset = 1'b1;
      #1;
      checkOutput("rst_add_write", registra_jogada, 0);
      checkOutput("rst_add_estado", db_estado, S_INICIAL);
      checkOutput("rst_add_endereco", endereco, 0);
      checkOutput("rst_add_vidas", vidas, VIDAS_P);
      tick();
      checkOutput("rst_add_write_held", registra_jogada, 0);
      checkOutput("rst_add_estado_held", db_estado, S_INICIAL);
      jogada = 1'b0;
      reset = 1'b0;
      tick();

      // Random games with random modes, press delays and mistakes.
      for (int g = 0; g < 10; g++) begin
         playGame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
